// File: rtl/az_sample_accum_pkg.sv
// Shared definitions for the auto-zero sample accumulator: state encodings,
// sticky flag bit positions and default widths.
package az_sample_accum_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StAccSig   = 3'd1,
        StWaitZero = 3'd2,
        StAccZero  = 3'd3,
        StPublish  = 3'd4
    } az_state_e;

    // Bit positions inside the 3-bit flags vector {sat, seq_err, overrun}.
    localparam int unsigned FlagSat     = 2;
    localparam int unsigned FlagSeqErr  = 1;
    localparam int unsigned FlagOverrun = 0;

    localparam int unsigned DefDataW = 24;
    localparam int unsigned DefAccW  = 32;
    localparam int unsigned DefCntW  = 16;

endpackage

// File: rtl/az_sample_accum_sat_add_signed.sv
// Signed W-bit add/subtract with overflow detect; clamps to the signed range
// when AZ_ACCUM_SATURATE_EN is defined, otherwise wraps.
module sat_add_signed #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y,
    output logic         o_ovf
);

    logic [W:0] w_full;
    logic       w_ovf;

    always_comb begin
        if (i_sub) begin
            w_full = {i_a[W-1], i_a} - {i_b[W-1], i_b};
        end else begin
            w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
        end
    end

    assign w_ovf = w_full[W] ^ w_full[W-1];
    assign o_ovf = w_ovf;

`ifdef AZ_ACCUM_SATURATE_EN
    always_comb begin
        o_y = w_full[W-1:0];
        if (w_ovf) begin
            // Sign of the wide result tells which rail was crossed.
            o_y = w_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign o_y = w_full[W-1:0];
`endif

endmodule

// File: rtl/az_sample_accum.sv
// Accumulates ADC words over the signal then zero window of one auto-zero cycle and
// publishes sums, difference and counts. AZ_ACCUM_SATURATE_EN selects clamping arithmetic.
module az_sample_accum
    import az_sample_accum_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ACC_W  = DefAccW,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_sig,
    input  logic              sample_zero,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              clear_flags,
    input  logic              result_ready,
    output logic              result_valid,
    output logic [ACC_W-1:0]  result_sig,
    output logic [ACC_W-1:0]  result_zero,
    output logic [ACC_W-1:0]  result_diff,
    output logic [CNT_W-1:0]  result_cnt_sig,
    output logic [CNT_W-1:0]  result_cnt_zero,
    output logic [2:0]        flags,
    output logic [6:0]        vec_monitor
);

`ifdef AZ_ACCUM_SATURATE_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    az_state_e        r_state, w_state_d;
    logic             r_sig_q, r_zero_q, r_primed;
    logic [ACC_W-1:0] r_acc_sig, r_acc_zero, w_acc_sig_d, w_acc_zero_d;
    logic [CNT_W-1:0] r_cnt_sig, r_cnt_zero, w_cnt_sig_d, w_cnt_zero_d;
    logic [ACC_W-1:0] r_res_sig, r_res_zero, r_res_diff;
    logic [ACC_W-1:0] w_res_sig_d, w_res_zero_d, w_res_diff_d;
    logic [CNT_W-1:0] r_res_cnt_sig, r_res_cnt_zero, w_res_cnt_sig_d, w_res_cnt_zero_d;
    logic             r_res_valid, w_res_valid_d;
    logic [2:0]       r_flags, w_flags_d;

    logic             w_sig_rise, w_sig_fall, w_zero_rise, w_zero_fall, w_seq_err;
    logic [ACC_W-1:0] w_ext, w_sig_base, w_zero_base;
    logic [ACC_W-1:0] w_sig_sum, w_zero_sum, w_diff;
    logic             w_sig_ovf, w_zero_ovf, w_diff_ovf;
    logic [CNT_W-1:0] w_cnt_sig_base, w_cnt_zero_base, w_cnt_sig_inc, w_cnt_zero_inc;
    logic             w_sat_set, w_ovr_set;

    // Edges are suppressed on the first cycle after reset so a window that was
    // already high at release is not mistaken for a fresh rise.
    assign w_sig_rise  = r_primed & sample_sig & ~r_sig_q;
    assign w_sig_fall  = ~sample_sig & r_sig_q;
    assign w_zero_rise = r_primed & sample_zero & ~r_zero_q;
    assign w_zero_fall = ~sample_zero & r_zero_q;

    assign w_seq_err = (sample_sig & sample_zero) |
                       (w_zero_rise & ((r_state == StIdle) | (r_state == StAccSig)));

    assign w_ext = ACC_W'($signed(adc_data));

    // Outside the accumulate states the adders start from zero (window start).
    assign w_sig_base      = (r_state == StAccSig)  ? r_acc_sig  : '0;
    assign w_zero_base     = (r_state == StAccZero) ? r_acc_zero : '0;
    assign w_cnt_sig_base  = (r_state == StAccSig)  ? r_cnt_sig  : '0;
    assign w_cnt_zero_base = (r_state == StAccZero) ? r_cnt_zero : '0;

    assign w_cnt_sig_inc  = (&w_cnt_sig_base)  ? w_cnt_sig_base  : w_cnt_sig_base + CNT_W'(1);
    assign w_cnt_zero_inc = (&w_cnt_zero_base) ? w_cnt_zero_base : w_cnt_zero_base + CNT_W'(1);

    sat_add_signed #(.W(ACC_W)) u_add_sig (
        .i_a   (w_sig_base),
        .i_b   (w_ext),
        .i_sub (1'b0),
        .o_y   (w_sig_sum),
        .o_ovf (w_sig_ovf)
    );

    sat_add_signed #(.W(ACC_W)) u_add_zero (
        .i_a   (w_zero_base),
        .i_b   (w_ext),
        .i_sub (1'b0),
        .o_y   (w_zero_sum),
        .o_ovf (w_zero_ovf)
    );

    sat_add_signed #(.W(ACC_W)) u_diff (
        .i_a   (r_acc_sig),
        .i_b   (r_acc_zero),
        .i_sub (1'b1),
        .o_y   (w_diff),
        .o_ovf (w_diff_ovf)
    );

    always_comb begin
        w_state_d        = r_state;
        w_acc_sig_d      = r_acc_sig;
        w_acc_zero_d     = r_acc_zero;
        w_cnt_sig_d      = r_cnt_sig;
        w_cnt_zero_d     = r_cnt_zero;
        w_res_sig_d      = r_res_sig;
        w_res_zero_d     = r_res_zero;
        w_res_diff_d     = r_res_diff;
        w_res_cnt_sig_d  = r_res_cnt_sig;
        w_res_cnt_zero_d = r_res_cnt_zero;
        w_res_valid_d    = r_res_valid & ~result_ready;
        w_sat_set        = 1'b0;
        w_ovr_set        = 1'b0;

        if (w_seq_err) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_sig_rise) begin
                        w_state_d   = StAccSig;
                        w_acc_sig_d = adc_valid ? w_sig_sum : '0;
                        w_cnt_sig_d = adc_valid ? w_cnt_sig_inc : '0;
                    end
                end
                StAccSig: begin
                    if (w_sig_fall) begin
                        w_state_d = StWaitZero;
                    end else if (adc_valid) begin
                        w_acc_sig_d = w_sig_sum;
                        w_cnt_sig_d = w_cnt_sig_inc;
                        w_sat_set   = w_sig_ovf;
                    end
                end
                StWaitZero: begin
                    if (w_zero_rise) begin
                        w_state_d    = StAccZero;
                        w_acc_zero_d = adc_valid ? w_zero_sum : '0;
                        w_cnt_zero_d = adc_valid ? w_cnt_zero_inc : '0;
                    end else if (w_sig_rise) begin
                        // Signal-only mode: previous signal data is discarded silently.
                        w_state_d   = StAccSig;
                        w_acc_sig_d = adc_valid ? w_sig_sum : '0;
                        w_cnt_sig_d = adc_valid ? w_cnt_sig_inc : '0;
                    end
                end
                StAccZero: begin
                    if (w_zero_fall) begin
                        w_state_d = StPublish;
                    end else if (adc_valid) begin
                        w_acc_zero_d = w_zero_sum;
                        w_cnt_zero_d = w_cnt_zero_inc;
                        w_sat_set    = w_zero_ovf;
                    end
                end
                StPublish: begin
                    w_state_d = StIdle;
                    if (!r_res_valid || result_ready) begin
                        w_res_sig_d      = r_acc_sig;
                        w_res_zero_d     = r_acc_zero;
                        w_res_diff_d     = w_diff;
                        w_res_cnt_sig_d  = r_cnt_sig;
                        w_res_cnt_zero_d = r_cnt_zero;
                        w_res_valid_d    = 1'b1;
                        w_sat_set        = w_diff_ovf;
                    end else begin
                        w_ovr_set = 1'b1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end

        // Clear first so that a flag raised in the same cycle survives.
        w_flags_d = clear_flags ? 3'b000 : r_flags;
        if (w_sat_set && SatEn) w_flags_d[FlagSat] = 1'b1;
        if (w_seq_err)          w_flags_d[FlagSeqErr] = 1'b1;
        if (w_ovr_set)          w_flags_d[FlagOverrun] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sig_q        <= 1'b0;
            r_zero_q       <= 1'b0;
            r_primed       <= 1'b0;
            r_acc_sig      <= '0;
            r_acc_zero     <= '0;
            r_cnt_sig      <= '0;
            r_cnt_zero     <= '0;
            r_res_sig      <= '0;
            r_res_zero     <= '0;
            r_res_diff     <= '0;
            r_res_cnt_sig  <= '0;
            r_res_cnt_zero <= '0;
            r_res_valid    <= 1'b0;
            r_flags        <= 3'b000;
        end else begin
            r_sig_q        <= sample_sig;
            r_zero_q       <= sample_zero;
            r_primed       <= 1'b1;
            r_acc_sig      <= w_acc_sig_d;
            r_acc_zero     <= w_acc_zero_d;
            r_cnt_sig      <= w_cnt_sig_d;
            r_cnt_zero     <= w_cnt_zero_d;
            r_res_sig      <= w_res_sig_d;
            r_res_zero     <= w_res_zero_d;
            r_res_diff     <= w_res_diff_d;
            r_res_cnt_sig  <= w_res_cnt_sig_d;
            r_res_cnt_zero <= w_res_cnt_zero_d;
            r_res_valid    <= w_res_valid_d;
            r_flags        <= w_flags_d;
        end
    end

    assign result_valid    = r_res_valid;
    assign result_sig      = r_res_sig;
    assign result_zero     = r_res_zero;
    assign result_diff     = r_res_diff;
    assign result_cnt_sig  = r_res_cnt_sig;
    assign result_cnt_zero = r_res_cnt_zero;
    assign flags           = r_flags;
    assign vec_monitor     = {r_state, sample_sig, sample_zero, adc_valid, r_res_valid};

endmodule
